// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage request bundle: redirect inputs, IM handshake and PC outputs.
// master = the PC unit, slave = the consumer/driver side (pipeline control and IM).
interface fetch_pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              En;
    logic              Br_valid;
    logic [ADDR_W-1:0] Br_target;
    logic              Exc_req;
    logic              Eret_req;
    logic [ADDR_W-1:0] Epc;
    logic              Req_ready;
    logic              Req_valid;
    logic [ADDR_W-1:0] PC;
    logic [ADDR_W-1:0] PC_next;
    logic              Misalign;

    modport master (
        input  En, Br_valid, Br_target, Exc_req, Eret_req, Epc, Req_ready,
        output Req_valid, PC, PC_next, Misalign
    );

    modport slave (
        output En, Br_valid, Br_target, Exc_req, Eret_req, Epc, Req_ready,
        input  Req_valid, PC, PC_next, Misalign
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC with prioritised redirects (Exc > Eret > Br), a one-deep pending
// redirect buffer held across non-fire cycles, and a FAULT state for misaligned targets.
module fetch_pc_unit #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] EXC_VEC     = ADDR_W'(32'h0000_4180),
    parameter int                STEP        = 4,
    parameter bit                ALIGN_CHECK = 1'b1
) (
    input logic             Clk,
    input logic             Reset_n,
    fetch_pc_unit_if.master io_fetch
);
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_ERET = 2'd2;
    localparam logic [1:0] PRI_EXC  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_pend_vld;
    logic [1:0]        r_pend_pri;
    logic [ADDR_W-1:0] r_pend_tgt;

    logic              w_fire;
    logic [ADDR_W-1:0] w_pc_next;
    logic [1:0]        w_new_pri;
    logic [ADDR_W-1:0] w_new_tgt;
    logic              w_take_new;
    logic              w_sel_vld;
    logic [1:0]        w_sel_pri;
    logic [ADDR_W-1:0] w_sel_tgt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_bad;

    // Without alignment checking, redirect targets are snapped to a word boundary;
    // the exception vector is a trusted constant and passes through untouched.
    function automatic logic [ADDR_W-1:0] fix_target(input logic [ADDR_W-1:0] tgt,
                                                     input logic [1:0]        pri);
        if (!ALIGN_CHECK && pri != PRI_EXC)
            return {tgt[ADDR_W-1:2], 2'b00};
        return tgt;
    endfunction

    function automatic logic target_misaligned(input logic [ADDR_W-1:0] tgt,
                                               input logic [1:0]        pri);
        return ALIGN_CHECK && (pri != PRI_EXC) && (tgt[1:0] != 2'b00);
    endfunction

    assign io_fetch.Req_valid = (r_state == S_RUN) && io_fetch.En;
    assign w_fire             = io_fetch.Req_valid && io_fetch.Req_ready;
    assign w_pc_next          = r_pc + ADDR_W'(STEP);
    assign io_fetch.PC        = r_pc;
    assign io_fetch.PC_next   = w_pc_next;
    assign io_fetch.Misalign  = (r_state == S_FAULT);

    always_comb begin
        w_new_pri = PRI_NONE;
        w_new_tgt = r_pc;
        if (io_fetch.Exc_req) begin
            w_new_pri = PRI_EXC;
            w_new_tgt = EXC_VEC;
        end else if (io_fetch.Eret_req) begin
            w_new_pri = PRI_ERET;
            w_new_tgt = io_fetch.Epc;
        end else if (io_fetch.Br_valid) begin
            w_new_pri = PRI_BR;
            w_new_tgt = io_fetch.Br_target;
        end
    end

    // A new redirect beats the buffered one on equal priority, so the newest wins ties.
    assign w_take_new = (w_new_pri != PRI_NONE) && (!r_pend_vld || (w_new_pri >= r_pend_pri));
    assign w_sel_vld  = w_take_new || r_pend_vld;
    assign w_sel_pri  = w_take_new ? w_new_pri : r_pend_pri;
    assign w_sel_tgt  = w_take_new ? w_new_tgt : r_pend_tgt;
    assign w_sel_addr = fix_target(w_sel_tgt, w_sel_pri);
    assign w_sel_bad  = target_misaligned(w_sel_tgt, w_sel_pri);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VEC;
            r_pend_vld <= 1'b0;
            r_pend_pri <= PRI_NONE;
        end else if (r_state == S_FAULT) begin
            // Only an exception gets out of FAULT, independent of the IM handshake.
            if (io_fetch.Exc_req) begin
                r_state    <= S_RUN;
                r_pc       <= EXC_VEC;
                r_pend_vld <= 1'b0;
                r_pend_pri <= PRI_NONE;
            end
        end else begin
            if (r_state == S_BOOT)
                r_state <= S_RUN;
            if (w_fire) begin
                r_pc       <= w_sel_vld ? w_sel_addr : w_pc_next;
                r_pend_vld <= 1'b0;
                r_pend_pri <= PRI_NONE;
                if (w_sel_vld && w_sel_bad)
                    r_state <= S_FAULT;
            end else if (w_take_new) begin
                r_pend_vld <= 1'b1;
                r_pend_pri <= w_new_pri;
            end
        end
    end

    // Buffered target is plain data; its valid bit alone qualifies it.
    always_ff @(posedge Clk) begin
        if (!w_fire && w_take_new)
            r_pend_tgt <= w_new_tgt;
    end
endmodule
